// File: rtl/operand_fetch.sv
// operand_fetch: scoreboarded operand-read stage with writeback bypass and a single output register.
module operand_fetch (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_opcode,
  input  logic [5:0]  in_src1,
  input  logic [5:0]  in_src2,
  input  logic [5:0]  in_src3,
  input  logic [2:0]  in_use,
  input  logic [5:0]  in_dst,
  input  logic        in_dst_we,
  output logic [5:0]  reg_rd1,
  output logic [5:0]  reg_rd2,
  output logic [5:0]  reg_rd3,
  input  logic [15:0] reg_rd1_out,
  input  logic [15:0] reg_rd2_out,
  input  logic [15:0] reg_rd3_out,
  input  logic        wb_wr1_enable,
  input  logic        wb_wr2_enable,
  input  logic [5:0]  wb_wr1_addr,
  input  logic [5:0]  wb_wr2_addr,
  input  logic [15:0] wb_wr1_data,
  input  logic [15:0] wb_wr2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_opcode,
  output logic [15:0] out_a,
  output logic [15:0] out_b,
  output logic [15:0] out_c,
  output logic [5:0]  out_dst,
  output logic        out_dst_we
);
  logic [63:0] pending_q, pending_d;
  logic        valid_q, valid_d, dst_we_q, dst_we_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [5:0]  dst_q, dst_d;
  logic [5:0]  src [3];
  logic [15:0] rdat [3];
  logic [15:0] opnd [3];
  logic [2:0]  hit1, hit2, haz;
  logic        dst_hit, waw, accept, kill;
  assign reg_rd1 = in_src1;
  assign reg_rd2 = in_src2;
  assign reg_rd3 = in_src3;
  assign src[0] = in_src1;
  assign src[1] = in_src2;
  assign src[2] = in_src3;
  assign rdat[0] = reg_rd1_out;
  assign rdat[1] = reg_rd2_out;
  assign rdat[2] = reg_rd3_out;
  genvar i;
  for (i = 0; i < 3; i++) begin : g_src
    assign hit1[i] = wb_wr1_enable && (wb_wr1_addr == src[i]);
    assign hit2[i] = wb_wr2_enable && (wb_wr2_addr == src[i]);
    // A same-cycle writeback resolves the dependency, so it is not a hazard.
    assign haz[i]  = in_use[i] && pending_q[src[i]] && !hit1[i] && !hit2[i];
    assign opnd[i] = hit2[i] ? wb_wr2_data : hit1[i] ? wb_wr1_data : rdat[i];
  end
  assign dst_hit  = (wb_wr1_enable && (wb_wr1_addr == in_dst)) || (wb_wr2_enable && (wb_wr2_addr == in_dst));
  assign waw      = in_dst_we && pending_q[in_dst] && !dst_hit;
  assign in_ready = !reset && !flush && !(|haz) && !waw && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign kill     = flush && valid_q && dst_we_q;
  // Order matters: writeback and flush clears first, then set-on-accept wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_wr1_enable) pending_d[wb_wr1_addr] = 1'b0;
    if (wb_wr2_enable) pending_d[wb_wr2_addr] = 1'b0;
    if (kill) pending_d[dst_q] = 1'b0;
    if (accept && in_dst_we) pending_d[in_dst] = 1'b1;
  end
  always_comb begin
    valid_d  = accept || (valid_q && !out_ready && !flush);
    opcode_d = accept ? in_opcode : opcode_q;
    a_d      = accept ? opnd[0] : a_q;
    b_d      = accept ? opnd[1] : b_q;
    c_d      = accept ? opnd[2] : c_q;
    dst_d    = accept ? in_dst : dst_q;
    dst_we_d = accept ? in_dst_we : dst_we_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      dst_q     <= '0;
      dst_we_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      dst_q     <= dst_d;
      dst_we_q  <= dst_we_d;
    end
  end
  assign out_valid  = valid_q;
  assign out_opcode = opcode_q;
  assign out_a      = a_q;
  assign out_b      = b_q;
  assign out_c      = c_q;
  assign out_dst    = dst_q;
  assign out_dst_we = dst_we_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: table-driven vectors plus hand-written hazard, stall, flush and reset sequences.
module tb_operand_fetch;
  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, in_dst_we;
  logic [7:0]  in_opcode;
  logic [5:0]  in_src1, in_src2, in_src3, in_dst;
  logic [2:0]  in_use;
  logic [5:0]  reg_rd1, reg_rd2, reg_rd3;
  logic [15:0] reg_rd1_out, reg_rd2_out, reg_rd3_out;
  logic        wb_wr1_enable, wb_wr2_enable;
  logic [5:0]  wb_wr1_addr, wb_wr2_addr;
  logic [15:0] wb_wr1_data, wb_wr2_data;
  logic        flush, out_valid, out_ready, out_dst_we;
  logic [7:0]  out_opcode;
  logic [15:0] out_a, out_b, out_c;
  logic [5:0]  out_dst;
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  operand_fetch dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_src1(in_src1), .in_src2(in_src2), .in_src3(in_src3),
    .in_use(in_use), .in_dst(in_dst), .in_dst_we(in_dst_we),
    .reg_rd1(reg_rd1), .reg_rd2(reg_rd2), .reg_rd3(reg_rd3),
    .reg_rd1_out(reg_rd1_out), .reg_rd2_out(reg_rd2_out), .reg_rd3_out(reg_rd3_out),
    .wb_wr1_enable(wb_wr1_enable), .wb_wr2_enable(wb_wr2_enable),
    .wb_wr1_addr(wb_wr1_addr), .wb_wr2_addr(wb_wr2_addr),
    .wb_wr1_data(wb_wr1_data), .wb_wr2_data(wb_wr2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .out_dst(out_dst), .out_dst_we(out_dst_we)
  );

  typedef struct {
    logic [7:0]  op;
    logic [5:0]  s1, s2, s3;
    logic [2:0]  uses;
    logic [15:0] r1, r2, r3;
    logic        w1e;
    logic [5:0]  w1a;
    logic [15:0] w1d;
    logic        w2e;
    logic [5:0]  w2a;
    logic [15:0] w2d;
    logic [15:0] ea, eb, ec;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    in_valid = 0; in_opcode = 0; in_src1 = 0; in_src2 = 0; in_src3 = 0;
    in_use = 0; in_dst = 0; in_dst_we = 0;
    reg_rd1_out = 0; reg_rd2_out = 0; reg_rd3_out = 0;
    wb_wr1_enable = 0; wb_wr2_enable = 0; wb_wr1_addr = 0; wb_wr2_addr = 0;
    wb_wr1_data = 0; wb_wr2_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [5:0] s1, input logic [2:0] uses,
                       input logic [5:0] dst, input logic we);
    in_valid = 1; in_opcode = op; in_src1 = s1; in_src2 = 0; in_src3 = 0;
    in_use = uses; in_dst = dst; in_dst_we = we;
  endtask

  initial begin
    vecs[0] = '{8'h10, 6'd3, 6'd0, 6'd0, 3'b001, 16'h1234, 16'hAAAA, 16'h5555,
                1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0, 16'h1234, 16'hAAAA, 16'h5555};
    vecs[1] = '{8'h11, 6'd0, 6'd7, 6'd0, 3'b010, 16'h0001, 16'h0002, 16'h0003,
                1'b1, 6'd7, 16'h1111, 1'b1, 6'd7, 16'h2222, 16'h0001, 16'h2222, 16'h0003};
    vecs[2] = '{8'h12, 6'd1, 6'd2, 6'd10, 3'b111, 16'h0A0A, 16'h0B0B, 16'h0C0C,
                1'b1, 6'd10, 16'h3333, 1'b0, 6'd0, 16'h0, 16'h0A0A, 16'h0B0B, 16'h3333};
    vecs[3] = '{8'h13, 6'd1, 6'd2, 6'd3, 3'b111, 16'h0, 16'h0, 16'h0,
                1'b1, 6'd1, 16'h4444, 1'b1, 6'd2, 16'h5555, 16'h4444, 16'h5555, 16'h0000};
    vecs[3].w2a = 6'd2;
    vecs[4] = '{8'h14, 6'd0, 6'd0, 6'd0, 3'b111, 16'h1, 16'h2, 16'h3,
                1'b1, 6'd0, 16'h6666, 1'b1, 6'd0, 16'h7777, 16'h7777, 16'h7777, 16'h7777};
    vecs[5] = '{8'h15, 6'd6, 6'd6, 6'd6, 3'b111, 16'h8, 16'h9, 16'hA,
                1'b0, 6'd6, 16'hBBBB, 1'b0, 6'd6, 16'hCCCC, 16'h8, 16'h9, 16'hA};
    idle();
    reset = 1;
    #1;
    chk("ready_in_reset", {31'd0, in_ready}, 32'd0);
    tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_opcode", {24'd0, out_opcode}, 32'd0);
    chk("rst_a", {16'd0, out_a}, 32'd0);
    chk("rst_dst_we", {31'd0, out_dst_we}, 32'd0);
    reset = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1; in_opcode = vecs[k].op;
      in_src1 = vecs[k].s1; in_src2 = vecs[k].s2; in_src3 = vecs[k].s3; in_use = vecs[k].uses;
      in_dst = 6'(20 + k); in_dst_we = 0;
      reg_rd1_out = vecs[k].r1; reg_rd2_out = vecs[k].r2; reg_rd3_out = vecs[k].r3;
      wb_wr1_enable = vecs[k].w1e; wb_wr1_addr = vecs[k].w1a; wb_wr1_data = vecs[k].w1d;
      wb_wr2_enable = vecs[k].w2e; wb_wr2_addr = vecs[k].w2a; wb_wr2_data = vecs[k].w2d;
      #1;
      chk($sformatf("v%0d_ready", k), {31'd0, in_ready}, 32'd1);
      chk($sformatf("v%0d_rd", k), {14'd0, reg_rd1, reg_rd2, reg_rd3}, {14'd0, vecs[k].s1, vecs[k].s2, vecs[k].s3});
      tick();
      chk($sformatf("v%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_opcode", k), {24'd0, out_opcode}, {24'd0, vecs[k].op});
      chk($sformatf("v%0d_abc", k), {out_a, out_b}, {vecs[k].ea, vecs[k].eb});
      chk($sformatf("v%0d_c", k), {16'd0, out_c}, {16'd0, vecs[k].ec});
      chk($sformatf("v%0d_dst", k), {26'd0, out_dst}, 32'(20 + k));
    end
    idle(); tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    issue(8'h20, 6'd0, 3'b000, 6'd5, 1'b1); #1;
    chk("prod_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("prod_dst", {25'd0, out_dst_we, out_dst}, {25'd0, 1'b1, 6'd5});
    issue(8'h21, 6'd5, 3'b001, 6'd0, 1'b0); #1;
    chk("raw_stall0", {31'd0, in_ready}, 32'd0);
    tick();
    chk("raw_drained", {31'd0, out_valid}, 32'd0);
    chk("raw_stall1", {31'd0, in_ready}, 32'd0);
    issue(8'h22, 6'd0, 3'b000, 6'd5, 1'b1); #1;
    chk("waw_stall", {31'd0, in_ready}, 32'd0);
    issue(8'h21, 6'd5, 3'b001, 6'd0, 1'b0);
    wb_wr1_enable = 1; wb_wr1_addr = 5; wb_wr1_data = 16'hBEEF; #1;
    chk("raw_wb_ready", {31'd0, in_ready}, 32'd1);
    tick(); idle();
    chk("raw_out_a", {16'd0, out_a}, 32'h0000BEEF);
    chk("raw_out_op", {31'd0, out_valid, out_opcode} , {23'd0, 1'b1, 8'h21});
    in_src1 = 5; in_use = 3'b001; #1;
    chk("r5_cleared", {31'd0, in_ready}, 32'd1);
    tick();

    issue(8'h30, 6'd0, 3'b000, 6'd12, 1'b1);
    wb_wr1_enable = 1; wb_wr1_addr = 12; #1;
    chk("set_ready", {31'd0, in_ready}, 32'd1);
    tick(); idle();
    issue(8'h31, 6'd12, 3'b001, 6'd0, 1'b0); #1;
    chk("set_wins", {31'd0, in_ready}, 32'd0);
    wb_wr2_enable = 1; wb_wr2_addr = 12; wb_wr2_data = 16'h1212; #1;
    chk("wr2_clear_ready", {31'd0, in_ready}, 32'd1);
    tick(); idle();
    chk("wr2_bypass", {16'd0, out_a}, 32'h00001212);

    issue(8'h42, 6'd0, 3'b000, 6'd0, 1'b0); #1;
    tick(); idle();
    out_ready = 0;
    issue(8'h43, 6'd0, 3'b000, 6'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_ready", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp%0d_hold", k), {23'd0, out_valid, out_opcode}, {23'd0, 1'b1, 8'h42});
      tick();
    end
    out_ready = 1; #1;
    chk("bp_release", {31'd0, in_ready}, 32'd1);
    tick(); idle();
    chk("bp_next", {23'd0, out_valid, out_opcode}, {23'd0, 1'b1, 8'h43});
    tick();

    issue(8'h50, 6'd0, 3'b000, 6'd9, 1'b1); #1;
    tick(); idle();
    chk("fl_pre", {25'd0, out_valid, out_dst}, {25'd0, 1'b1, 6'd9});
    out_ready = 0; flush = 1;
    issue(8'h51, 6'd0, 3'b000, 6'd0, 1'b0); #1;
    chk("flush_blocks", {31'd0, in_ready}, 32'd0);
    tick(); idle();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_no_accept", {24'd0, out_opcode}, 32'h50);
    issue(8'h52, 6'd9, 3'b001, 6'd0, 1'b0);
    reg_rd1_out = 16'h9999; #1;
    chk("r9_free", {31'd0, in_ready}, 32'd1);
    tick(); idle();
    chk("r9_out_a", {16'd0, out_a}, 32'h00009999);

    issue(8'h60, 6'd0, 3'b000, 6'd4, 1'b1); #1;
    tick();
    issue(8'h61, 6'd4, 3'b001, 6'd0, 1'b0);
    reg_rd1_out = 16'h4444; #1;
    chk("r4_stall", {31'd0, in_ready}, 32'd0);
    reset = 1; #1;
    chk("rst_blocks", {31'd0, in_ready}, 32'd0);
    tick();
    reset = 0; #1;
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_fields", {out_opcode, out_dst, out_dst_we}, 32'd0);
    chk("rst2_a", {16'd0, out_a}, 32'd0);
    chk("r4_free", {31'd0, in_ready}, 32'd1);
    tick(); idle();
    chk("r4_issue", {7'd0, out_valid, out_opcode, out_a}, {7'd0, 1'b1, 8'h61, 16'h4444});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
